aes_round_sched: RTL

Sequences one AES block encryption over the 16-entry XMM register file. The block drives the file's data and key read indices, counts rounds (10/12/14 by key size), and handshakes each round with the round datapath. Each round result is written back to a destination register. It sits between the instruction decode/issue logic, which supplies start, mode and register indices, and the register file plus round unit.

---
 rtl/aes_round_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// aes_round_sched: sequences one AES block encryption over the 16-entry XMM register file.
// It drives the register file read indices, counts rounds (10/12/14 by key size) and
// handshakes each round with the round datapath. Each round's result goes to one
// destination register.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           request a block encryption (taken only while start_ready=1)
//   start_ready     high in IDLE only
//   mode            00=AES-128, 01=AES-192, 10=AES-256, 11=illegal (rejected with err)
//   src_reg         plaintext register, read in round 0 only
//   dst_reg         destination register for every round result
//   key_base        register holding round key 0; round key r lives at key_base+r
//   data_reg        register file data read index
//   key_reg         register file key read index
//   rnd_valid       round operation presented to the round unit
//   rnd_ready       round unit accepts the operation
//   rnd_first       round 0 (AddRoundKey only)
//   rnd_last        final round (no MixColumns)
//   wb_en, wb_reg   register file write-back enable and index
//   busy            high from start acceptance through the done/err cycle
//   done            one-cycle pulse after the final write-back
//   err             one-cycle pulse when an illegal mode is rejected
module aes_round_sched #(
    parameter int unsigned W_IDX  = 4,
    parameter int unsigned N_REGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [1:0]       mode,
    input  logic [W_IDX-1:0] src_reg,
    input  logic [W_IDX-1:0] dst_reg,
    input  logic [W_IDX-1:0] key_base,
    output logic [W_IDX-1:0] data_reg,
    output logic [W_IDX-1:0] key_reg,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             rnd_first,
    output logic             rnd_last,
    output logic             wb_en,
    output logic [W_IDX-1:0] wb_reg,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned SumW = W_IDX + 1;

    typedef enum logic [1:0] {StIdle, StRun, StErr, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [3:0]       nr_q, nr_d;       // index of the last round, fixed at start
    logic [W_IDX-1:0] src_q, dst_q, key_base_q;
    logic             accept;
    logic [SumW-1:0]  key_sum;
    logic [W_IDX-1:0] key_idx;

    assign accept = start && (state_q == StIdle);

    always_comb begin
        unique case (mode)
            2'b00:   nr_d = 4'd10;
            2'b01:   nr_d = 4'd12;
            default: nr_d = 4'd14;
        endcase
    end

    // Round key index wraps around the register file.
    always_comb begin
        key_sum = {1'b0, key_base_q} + SumW'(round_q);
        if (key_sum >= SumW'(N_REGS)) begin
            key_sum = key_sum - SumW'(N_REGS);
        end
        key_idx = key_sum[W_IDX-1:0];
    end

    // State register and start-time latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            round_q    <= 4'd0;
            nr_q       <= 4'd0;
            src_q      <= '0;
            dst_q      <= '0;
            key_base_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            if (accept) begin
                nr_q       <= nr_d;
                src_q      <= src_reg;
                dst_q      <= dst_reg;
                key_base_q <= key_base;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                round_d = 4'd0;
                if (start) begin
                    state_d = (mode == 2'b11) ? StErr : StRun;
                end
            end
            StRun: begin
                if (rnd_ready) begin
                    if (round_q == nr_q) begin
                        state_d = StDone;
                        round_d = 4'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            StErr:   state_d = StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs. Write-back and the done/err pulses are masked while reset is
    // asserted so nothing is committed in the reset cycle itself.
    always_comb begin
        start_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        data_reg    = '0;
        key_reg     = '0;
        rnd_valid   = 1'b0;
        rnd_first   = 1'b0;
        rnd_last    = 1'b0;
        wb_en       = 1'b0;
        wb_reg      = (state_q == StIdle) ? '0 : dst_q;
        done        = (state_q == StDone) && !rst;
        err         = (state_q == StErr) && !rst;
        if (state_q == StRun) begin
            rnd_valid = 1'b1;
            key_reg   = key_idx;
            data_reg  = (round_q == 4'd0) ? src_q : dst_q;
            rnd_first = (round_q == 4'd0);
            rnd_last  = (round_q == nr_q);
            wb_en     = rnd_ready && !rst;
        end
    end

endmodule
